// File: rtl/wide_add_seq.sv
// wide_add_seq: (32*WORDS)-bit add sequenced one 32-bit word per clock, LSW first, through one shared CLA.
// Define WIDE_ADD_SEQ_SUB_EN to add the `sub` port (a - b via inverted b words and carry-in of 1).

module wide_add_seq_cla32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] p;
    logic [31:0] g;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [32:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Two-level lookahead: 4-bit groups produce G/P, group carries feed the in-group carries.
    // NOTE: every variable written in this block gets a default first, so no latch can be inferred.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        c     = '0;
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            c[4*k+4] = grp_g[k] | (grp_p[k] & c[4*k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign s  = p ^ c[31:0];
    assign co = c[32];
endmodule

module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef WIDE_ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout
);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WORDS-1:0][31:0] a_r;
    logic [WORDS-1:0][31:0] b_r;
    logic [WORDS-1:0][31:0] sum_r;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_r;
    logic                   cout_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   last_word;
    logic                   init_carry;
    logic [31:0]            a_word;
    logic [31:0]            b_word;
    logic [31:0]            cla_s;
    logic                   cla_co;

    assign last_word = (idx_q == LAST_IDX);
    assign a_word    = a_r[idx_q];

`ifdef WIDE_ADD_SEQ_SUB_EN
    logic sub_r;

    // Subtraction is a + ~b + 1, so sub overrides cin with a forced carry-in.
    assign b_word     = sub_r ? ~b_r[idx_q] : b_r[idx_q];
    assign init_carry = sub ? 1'b1 : cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_r <= 1'b0;
        end else if (accept) begin
            sub_r <= sub;
        end
    end
`else
    assign b_word     = b_r[idx_q];
    assign init_carry = cin;
`endif

    wide_add_seq_cla32 u_cla (
        .x  (a_word),
        .y  (b_word),
        .ci (carry_r),
        .s  (cla_s),
        .co (cla_co)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end
            end
            S_RUN: begin
                if (last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the operand and sum word arrays are flops, not RAM, and are cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            idx_q   <= '0;
            carry_r <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_d == S_RUN);
            done_q <= (state_d == S_DONE);
            if (accept) begin
                a_r     <= a;
                b_r     <= b;
                carry_r <= init_carry;
                idx_q   <= '0;
            end else if (state_q == S_RUN) begin
                sum_r[idx_q] <= cla_s;
                carry_r      <= cla_co;
                if (last_word) begin
                    cout_q <= cla_co;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_r;
    assign cout = cout_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS=4): randomized and directed ops against an arithmetic model.
// Subtract checks are compiled in when WIDE_ADD_SEQ_SUB_EN is defined.

module tb_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub_drv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef WIDE_ADD_SEQ_SUB_EN
        .sub   (sub_drv),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain W+1 bit arithmetic; for subtract, difference mod 2^W and no-borrow flag.
    function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
        logic [W:0] t;
        if (s) begin
            t[W-1:0] = x - y;
            t[W]     = (x >= y);
        end else begin
            t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        end
        return t;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
        // Occasionally force long carry chains.
        if ($urandom_range(0, 3) == 0) v[W-1:32] = '1;
        return v;
    endfunction

    // Drives one request at the current point (#1 after an edge) and follows it to its done cycle.
    // Returns with time sitting in the done cycle; done_cyc = -1 means the bound expired.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, input logic op_sub,
                          output logic [W-1:0] got_sum, output logic got_cout,
                          output int done_cyc, output int busy_cnt);
        a       = op_a;
        b       = op_b;
        cin     = op_cin;
        sub_drv = op_sub;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        got_sum  = sum;
        got_cout = cout;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        sub_drv = 1'b0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b done=%b cout=%b sum=%h expected all zero",
                     busy, done, cout, sum);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vc [6];
        logic [W-1:0] got_sum;
        logic         got_cout;
        logic [W:0]   exp;
        int           dcyc;
        int           bcnt;
        logic [W-1:0] op_a;
        logic [W-1:0] op_b;
        logic         op_c;

        va[0] = {{(W-32){1'b0}}, 32'hFFFF_FFFF}; vb[0] = 1;       vc[0] = 1'b0;
        va[1] = '1;                               vb[1] = '0;      vc[1] = 1'b1;
        va[2] = '0;                               vb[2] = '0;      vc[2] = 1'b0;
        va[3] = '1;                               vb[3] = '1;      vc[3] = 1'b1;
        va[4] = {1'b1, {(W-1){1'b0}}};            vb[4] = va[4];   vc[4] = 1'b0;
        va[5] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        vb[5] = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF; vc[5] = 1'b1;

        for (int i = 0; i < 30; i++) begin
            if (i < 6) begin
                op_a = va[i];
                op_b = vb[i];
                op_c = vc[i];
            end else begin
                op_a = rand_word();
                op_b = rand_word();
                op_c = 1'($urandom_range(0, 1));
            end
            exp = ref_result(op_a, op_b, op_c, 1'b0);
            run_op(op_a, op_b, op_c, 1'b0, got_sum, got_cout, dcyc, bcnt);
            n_checks++;
            if (dcyc != WORDS + 1 || bcnt != WORDS) begin
                n_fail++;
                $display("FAIL add%0d_latency done_cycle=%0d busy_cycles=%0d expected %0d %0d",
                         i, dcyc, bcnt, WORDS + 1, WORDS);
            end
            n_checks++;
            if (got_sum !== exp[W-1:0] || got_cout !== exp[W]) begin
                n_fail++;
                $display("FAIL add%0d_result sum=%h cout=%b expected sum=%h cout=%b",
                         i, got_sum, got_cout, exp[W-1:0], exp[W]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({busy, done} !== 2'b00 || sum !== exp[W-1:0] || cout !== exp[W]) begin
                n_fail++;
                $display("FAIL add%0d_after_done busy=%b done=%b sum=%h cout=%b expected 0 0 and held result",
                         i, busy, done, sum, cout);
            end
        end
    endtask

    task automatic test_ignored_start();
        int done_cyc;
        int done_seen;
        done_cyc = -1;
        a     = W'(1);
        b     = W'(2);
        cin   = 1'b0;
        sub_drv = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a     = W'(7);
        b     = W'(7);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 3; c <= 20; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done_cyc != WORDS + 1 || sum !== W'(3) || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start done_cycle=%0d sum=%h cout=%b expected %0d sum=3 cout=0",
                     done_cyc, sum, cout, WORDS + 1);
        end
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        n_checks++;
        if (done_seen != 0 || sum !== W'(3)) begin
            n_fail++;
            $display("FAIL ignored_start_dropped active_cycles=%0d sum=%h expected 0 and sum=3",
                     done_seen, sum);
        end
    endtask

    task automatic test_mid_run_reset();
        logic [W-1:0] got_sum;
        logic         got_cout;
        int           dcyc;
        int           bcnt;
        a     = '1;
        b     = '1;
        cin   = 1'b1;
        sub_drv = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_busy busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, cout} !== 3'b000 || sum !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset busy=%b done=%b cout=%b sum=%h expected all zero",
                     busy, done, cout, sum);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(W'(10), W'(20), 1'b0, 1'b0, got_sum, got_cout, dcyc, bcnt);
        n_checks++;
        if (got_sum !== W'(30) || got_cout !== 1'b0 || dcyc != WORDS + 1) begin
            n_fail++;
            $display("FAIL midrun_recover sum=%h cout=%b done_cycle=%0d expected 30 0 %0d",
                     got_sum, got_cout, dcyc, WORDS + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got_sum;
        logic         got_cout;
        logic [W:0]   exp;
        logic [W-1:0] op_a;
        logic [W-1:0] op_b;
        logic         op_c;
        int           dcyc;
        int           bcnt;
        run_op(W'(100), W'(200), 1'b0, 1'b0, got_sum, got_cout, dcyc, bcnt);
        n_checks++;
        if (got_sum !== W'(300) || dcyc != WORDS + 1) begin
            n_fail++;
            $display("FAIL b2b_first sum=%h done_cycle=%0d expected 300 %0d", got_sum, dcyc, WORDS + 1);
        end
        // Issued from inside the DONE cycle: no IDLE cycle may appear in between.
        run_op(W'(5), W'(6), 1'b0, 1'b0, got_sum, got_cout, dcyc, bcnt);
        n_checks++;
        if (got_sum !== W'(11) || got_cout !== 1'b0 || dcyc != WORDS + 1 || bcnt != WORDS) begin
            n_fail++;
            $display("FAIL b2b_second sum=%h cout=%b done_cycle=%0d busy_cycles=%0d expected 11 0 %0d %0d",
                     got_sum, got_cout, dcyc, bcnt, WORDS + 1, WORDS);
        end
        for (int i = 0; i < 8; i++) begin
            op_a = rand_word();
            op_b = rand_word();
            op_c = 1'($urandom_range(0, 1));
            exp  = ref_result(op_a, op_b, op_c, 1'b0);
            run_op(op_a, op_b, op_c, 1'b0, got_sum, got_cout, dcyc, bcnt);
            n_checks++;
            if (got_sum !== exp[W-1:0] || got_cout !== exp[W] || dcyc != WORDS + 1) begin
                n_fail++;
                $display("FAIL b2b_rand%0d sum=%h cout=%b done_cycle=%0d expected sum=%h cout=%b %0d",
                         i, got_sum, got_cout, dcyc, exp[W-1:0], exp[W], WORDS + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef WIDE_ADD_SEQ_SUB_EN
    task automatic test_sub();
        logic [W-1:0] got_sum;
        logic         got_cout;
        logic [W:0]   exp;
        logic [W-1:0] op_a;
        logic [W-1:0] op_b;
        logic         op_c;
        logic         op_s;
        int           dcyc;
        int           bcnt;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0: begin op_a = W'(5); op_b = W'(3); op_c = 1'b0; op_s = 1'b1; end
                1: begin op_a = '0;    op_b = W'(1); op_c = 1'b0; op_s = 1'b1; end
                2: begin op_a = W'(9); op_b = W'(9); op_c = 1'b0; op_s = 1'b1; end
                3: begin op_a = W'(2); op_b = W'(7); op_c = 1'b1; op_s = 1'b1; end
                default: begin
                    op_a = rand_word();
                    op_b = rand_word();
                    op_c = 1'($urandom_range(0, 1));
                    op_s = 1'($urandom_range(0, 1));
                end
            endcase
            exp = ref_result(op_a, op_b, op_c, op_s);
            run_op(op_a, op_b, op_c, op_s, got_sum, got_cout, dcyc, bcnt);
            n_checks++;
            if (got_sum !== exp[W-1:0] || got_cout !== exp[W] || dcyc != WORDS + 1) begin
                n_fail++;
                $display("FAIL sub%0d sub=%b sum=%h cout=%b done_cycle=%0d expected sum=%h cout=%b %0d",
                         i, op_s, got_sum, got_cout, dcyc, exp[W-1:0], exp[W], WORDS + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_ignored_start();
        test_mid_run_reset();
        test_back_to_back();
`ifdef WIDE_ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
